// File: rtl/regs_wb_queue.sv
// Write-back queue for the 16x16 register file: merges ALU and memory results into an
// in-order FIFO, drains one entry per cycle to the write port, and exposes queued values.
module regs_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [AW-1:0]              mem_waddr_i,
    input  logic [DW-1:0]              mem_wdata_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [AW-1:0]              alu_waddr_i,
    input  logic [DW-1:0]              alu_wdata_i,
    output logic                       wen_o,
    output logic [AW-1:0]              waddr_o,
    output logic [DW-1:0]              wdata_o,
    input  logic [AW-1:0]              haz_raddr_i,
    output logic                       haz_hit_o,
    output logic [DW-1:0]              haz_data_o,
    output logic [$clog2(DEPTH):0]     q_count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free;
    logic          push_mem, push_alu, pop;
    logic [PW-1:0] alu_slot;

    // Space is judged on the registered count only; a same-cycle pop frees nothing.
    always_comb begin
        free        = CW'(DEPTH) - count_q;
        mem_ready_o = (free >= CW'(1));
        alu_ready_o = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid_i);
        push_mem    = mem_valid_i & mem_ready_o;
        push_alu    = alu_valid_i & alu_ready_o;
        pop         = (count_q != '0);
        alu_slot    = wr_ptr_q + PW'(push_mem);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push_mem) + PW'(push_alu);
        count_d  = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Mem entry takes the older slot when both producers push together.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (push_mem) begin
                addr_q[wr_ptr_q] <= mem_waddr_i;
                data_q[wr_ptr_q] <= mem_wdata_i;
            end
            if (push_alu) begin
                addr_q[alu_slot] <= alu_waddr_i;
                data_q[alu_slot] <= alu_wdata_i;
            end
        end
    end

    always_comb begin
        wen_o     = pop;
        waddr_o   = pop ? addr_q[rd_ptr_q] : '0;
        wdata_o   = pop ? data_q[rd_ptr_q] : '0;
        q_count_o = count_q;
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        haz_hit_o  = 1'b0;
        haz_data_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == haz_raddr_i)) begin
                haz_hit_o  = 1'b1;
                haz_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_regs_wb_queue.sv
// Directed bench for regs_wb_queue: a scoreboard queue mirrors the FIFO contents and
// checks readiness, drain order, hazard lookup and final register-file contents.
module tb_regs_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_valid, alu_valid;
    logic          mem_ready, alu_ready;
    logic [AW-1:0] mem_waddr, alu_waddr, waddr, haz_raddr;
    logic [DW-1:0] mem_wdata, alu_wdata, wdata, haz_data;
    logic          wen, haz_hit;
    logic [2:0]    q_count;

    int nvec  = 0;
    int nfail = 0;

    logic [AW+DW-1:0] sb [$];
    logic [DW-1:0]    ref_rf [16];
    logic [DW-1:0]    dut_rf [16];

    always #5 clk = ~clk;

    regs_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .mem_valid_i (mem_valid),
        .mem_ready_o (mem_ready),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .alu_valid_i (alu_valid),
        .alu_ready_o (alu_ready),
        .alu_waddr_i (alu_waddr),
        .alu_wdata_i (alu_wdata),
        .wen_o       (wen),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .haz_raddr_i (haz_raddr),
        .haz_hit_o   (haz_hit),
        .haz_data_o  (haz_data),
        .q_count_o   (q_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven; check mid-cycle, update the model, advance one edge.
    task automatic cycle();
        int               free;
        logic             exp_mr, exp_ar, exp_hit;
        logic [DW-1:0]    exp_hd;
        logic [AW+DW-1:0] head;
        #5;
        free   = int'(DEPTH) - sb.size();
        exp_mr = (free >= 1);
        exp_ar = (free >= 2) || ((free == 1) && !mem_valid);
        exp_hit = 1'b0;
        exp_hd  = '0;
        foreach (sb[i]) begin
            if (sb[i][AW+DW-1:DW] == haz_raddr) begin
                exp_hit = 1'b1;
                exp_hd  = sb[i][DW-1:0];
            end
        end
        head = (sb.size() != 0) ? sb[0] : '0;
        chk("mem_ready", 32'(mem_ready), 32'(exp_mr));
        chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
        chk("q_count", 32'(q_count), 32'(sb.size()));
        chk("wen", 32'(wen), 32'(sb.size() != 0));
        chk("waddr", 32'(waddr), 32'(head[AW+DW-1:DW]));
        chk("wdata", 32'(wdata), 32'(head[DW-1:0]));
        chk("haz_hit", 32'(haz_hit), 32'(exp_hit));
        chk("haz_data", 32'(haz_data), 32'(exp_hd));
        if (wen === 1'b1) dut_rf[waddr] = wdata;
        if (sb.size() != 0) begin
            head = sb.pop_front();
            ref_rf[head[AW+DW-1:DW]] = head[DW-1:0];
        end
        if (reset) begin
            sb.delete();
        end else begin
            if (mem_valid && exp_mr) sb.push_back({mem_waddr, mem_wdata});
            if (alu_valid && exp_ar) sb.push_back({alu_waddr, alu_wdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end
        reset = 1'b1;
        idle();
        mem_waddr = '0; mem_wdata = '0;
        alu_waddr = '0; alu_wdata = '0;
        haz_raddr = '0;
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            haz_raddr = AW'(i);
            cycle();
        end

        // Single ALU push
        alu_valid = 1'b1; alu_waddr = 4'd3; alu_wdata = 16'h1234; haz_raddr = 4'd3;
        cycle();
        idle();
        cycle();
        cycle();

        // Same-cycle mem and ALU push to r5
        mem_valid = 1'b1; mem_waddr = 4'd5; mem_wdata = 16'hAAAA;
        alu_valid = 1'b1; alu_waddr = 4'd5; alu_wdata = 16'hBBBB; haz_raddr = 4'd5;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // Both producers valid for 8 cycles
        for (int i = 0; i < 8; i++) begin
            mem_valid = 1'b1; mem_waddr = AW'(i);     mem_wdata = DW'(16'hC000 + i);
            alu_valid = 1'b1; alu_waddr = AW'(i + 8); alu_wdata = DW'(16'hD000 + i);
            haz_raddr = AW'(i);
            cycle();
        end
        idle();
        for (int i = 0; i < 5; i++) cycle();

        // Fill, then reset discards the queue
        for (int i = 0; i < 8 && sb.size() < DEPTH; i++) begin
            mem_valid = 1'b1; mem_waddr = 4'd9;  mem_wdata = DW'(16'hE000 + i);
            alu_valid = 1'b1; alu_waddr = 4'd10; alu_wdata = DW'(16'hF000 + i);
            haz_raddr = 4'd10;
            cycle();
        end
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) cycle();

        // Pointer wrap with alternating single pushes
        for (int i = 0; i < 20; i++) begin
            idle();
            if (i % 2 == 0) begin
                mem_valid = 1'b1; mem_waddr = AW'(i % 16); mem_wdata = DW'(16'h0100 + i);
            end else begin
                alu_valid = 1'b1; alu_waddr = AW'(i % 16); alu_wdata = DW'(16'h0100 + i);
            end
            haz_raddr = AW'($urandom_range(0, 15));
            cycle();
            idle();
            haz_raddr = AW'($urandom_range(0, 15));
            cycle();
        end
        for (int i = 0; i < 4; i++) cycle();

        for (int r = 0; r < 16; r++) chk("regfile", 32'(dut_rf[r]), 32'(ref_rf[r]));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
